// File: rtl/gshare_btb_branch_predictor_if.sv
// Signal bundle between fetch/execute and the gshare/BTB branch predictor.
interface gshare_btb_branch_predictor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int GHR_BITS   = 6
);
    // Fetch performs one lookup per cycle and has no handshake; stall_f only freezes speculative
    // state. The update side is valid-only: upd_valid qualifies every upd_* field for exactly
    // one cycle, there is no ready, and the predictor accepts every valid update.
    logic [DATA_WIDTH-1:0] pc_f;
    logic [DATA_WIDTH-1:0] instr_f;
    logic                  stall_f;
    logic                  predict_taken_f;
    logic [DATA_WIDTH-1:0] branch_target_f;
    logic [GHR_BITS-1:0]   ghr_f;
    logic                  upd_valid;
    logic [DATA_WIDTH-1:0] upd_pc;
    logic                  upd_is_cond;
    logic                  upd_is_jal;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;
    logic                  upd_mispredict;
    logic [GHR_BITS-1:0]   upd_ghr;

    modport master (
        output pc_f, instr_f, stall_f,
        output upd_valid, upd_pc, upd_is_cond, upd_is_jal, upd_taken, upd_target,
        output upd_mispredict, upd_ghr,
        input  predict_taken_f, branch_target_f, ghr_f
    );

    modport slave (
        input  pc_f, instr_f, stall_f,
        input  upd_valid, upd_pc, upd_is_cond, upd_is_jal, upd_taken, upd_target,
        input  upd_mispredict, upd_ghr,
        output predict_taken_f, branch_target_f, ghr_f
    );
endinterface

// File: rtl/gshare_btb_branch_predictor.sv
// Gshare direction predictor with a tagged direct-mapped BTB and a speculative, repairable GHR.
// Define RAS_EN to add a return address stack that predicts JALR returns.
module gshare_btb_branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int BTB_ROWS   = 16,
    parameter int PHT_ROWS   = 64,
    parameter int GHR_BITS   = 6,
    parameter int CTR_BITS   = 2,
    parameter int RAS_DEPTH  = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    gshare_btb_branch_predictor_if.slave bp
);
    localparam int IDX_BITS = $clog2(BTB_ROWS);
    localparam int PHT_BITS = $clog2(PHT_ROWS);
    localparam int TAG_BITS = DATA_WIDTH - IDX_BITS - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic                  btb_valid_q  [BTB_ROWS];
    logic                  btb_valid_d  [BTB_ROWS];
    logic [TAG_BITS-1:0]   btb_tag_q    [BTB_ROWS];
    logic [TAG_BITS-1:0]   btb_tag_d    [BTB_ROWS];
    logic [DATA_WIDTH-1:0] btb_target_q [BTB_ROWS];
    logic [DATA_WIDTH-1:0] btb_target_d [BTB_ROWS];
    logic [CTR_BITS-1:0]   pht_q        [PHT_ROWS];
    logic [CTR_BITS-1:0]   pht_d        [PHT_ROWS];
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;

    logic [6:0]            opcode_f;
    logic                  fetch_cond, fetch_jal;
    logic [IDX_BITS-1:0]   btb_idx_f, btb_idx_u;
    logic [TAG_BITS-1:0]   btb_tag_f, btb_tag_u;
    logic [PHT_BITS-1:0]   pht_idx_f, pht_idx_u;
    logic                  btb_hit_f;
    logic                  pred_taken;
    logic [DATA_WIDTH-1:0] pred_target;

    assign opcode_f   = bp.instr_f[6:0];
    assign fetch_cond = (opcode_f == OP_BRANCH);
    assign fetch_jal  = (opcode_f == OP_JAL);
    assign btb_idx_f  = bp.pc_f[IDX_BITS+1:2];
    assign btb_tag_f  = bp.pc_f[DATA_WIDTH-1:IDX_BITS+2];
    assign btb_idx_u  = bp.upd_pc[IDX_BITS+1:2];
    assign btb_tag_u  = bp.upd_pc[DATA_WIDTH-1:IDX_BITS+2];
    assign pht_idx_f  = bp.pc_f[PHT_BITS+1:2] ^ PHT_BITS'(ghr_q);
    assign pht_idx_u  = bp.upd_pc[PHT_BITS+1:2] ^ PHT_BITS'(bp.upd_ghr);
    assign btb_hit_f  = btb_valid_q[btb_idx_f] && (btb_tag_q[btb_idx_f] == btb_tag_f);

    logic unused_pc;
    assign unused_pc = &{1'b0, bp.pc_f[1:0], bp.upd_pc[1:0]};

`ifdef RAS_EN
    localparam int RAS_PTR_BITS = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [DATA_WIDTH-1:0]   ras_q [RAS_DEPTH];
    logic [DATA_WIDTH-1:0]   ras_d [RAS_DEPTH];
    logic [RAS_PTR_BITS-1:0] ras_ptr_q, ras_ptr_d, ras_top;
    logic [4:0]              rd_f, rs1_f;
    logic                    ras_push, ras_pop;

    assign rd_f     = bp.instr_f[11:7];
    assign rs1_f    = bp.instr_f[19:15];
    assign ras_top  = ras_ptr_q - 1'b1;
    assign ras_push = ((opcode_f == OP_JAL) || (opcode_f == OP_JALR)) &&
                      ((rd_f == 5'd1) || (rd_f == 5'd5));
    assign ras_pop  = (opcode_f == OP_JALR) && (rd_f == 5'd0) &&
                      ((rs1_f == 5'd1) || (rs1_f == 5'd5));

    // Pointer marks the next free slot; wrap silently overwrites the oldest return address.
    always_comb begin
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        if (!bp.stall_f) begin
            if (ras_push) begin
                ras_d[ras_ptr_q] = bp.pc_f + DATA_WIDTH'(4);
                ras_ptr_d        = ras_ptr_q + 1'b1;
            end else if (ras_pop) begin
                ras_ptr_d = ras_top;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ras_ptr_q <= '0;
        else        ras_ptr_q <= ras_ptr_d;
    end

    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    logic unused_instr;
    assign unused_instr = &{1'b0, bp.instr_f[31:20], bp.instr_f[14:12]};
`else
    logic unused_instr;
    assign unused_instr = &{1'b0, bp.instr_f[31:7], (RAS_DEPTH != 0)};
`endif

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = bp.pc_f;
        if (btb_hit_f && (fetch_jal || (fetch_cond && pht_q[pht_idx_f][CTR_BITS-1]))) begin
            pred_taken  = 1'b1;
            pred_target = btb_target_q[btb_idx_f];
        end
`ifdef RAS_EN
        if (ras_pop) begin
            pred_taken  = 1'b1;
            pred_target = ras_q[ras_top];
        end
`endif
    end

    assign bp.predict_taken_f = pred_taken;
    assign bp.branch_target_f = pred_target;
    assign bp.ghr_f           = ghr_q;

    // Execute-stage repair outranks the speculative shift of the instruction now in fetch.
    always_comb begin
        ghr_d = ghr_q;
        if (bp.upd_valid && bp.upd_mispredict && bp.upd_is_cond)
            ghr_d = GHR_BITS'({bp.upd_ghr, bp.upd_taken});
        else if (bp.upd_valid && bp.upd_mispredict && bp.upd_is_jal)
            ghr_d = bp.upd_ghr;
        else if (fetch_cond && !bp.stall_f)
            ghr_d = GHR_BITS'({ghr_q, pred_taken});
    end

    always_comb begin
        pht_d = pht_q;
        if (bp.upd_valid && bp.upd_is_cond) begin
            if (bp.upd_taken && (pht_q[pht_idx_u] != CTR_MAX))
                pht_d[pht_idx_u] = pht_q[pht_idx_u] + 1'b1;
            else if (!bp.upd_taken && (pht_q[pht_idx_u] != '0))
                pht_d[pht_idx_u] = pht_q[pht_idx_u] - 1'b1;
        end
    end

    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (bp.upd_valid && bp.upd_taken && (bp.upd_is_cond || bp.upd_is_jal)) begin
            btb_valid_d[btb_idx_u]  = 1'b1;
            btb_tag_d[btb_idx_u]    = btb_tag_u;
            btb_target_d[btb_idx_u] = bp.upd_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q        <= '0;
            pht_q        <= '{default: CTR_INIT};
            btb_valid_q  <= '{default: 1'b0};
            btb_tag_q    <= '{default: '0};
            btb_target_q <= '{default: '0};
        end else begin
            ghr_q        <= ghr_d;
            pht_q        <= pht_d;
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
        end
    end
endmodule

// File: tb/tb_gshare_btb_branch_predictor.sv
// Bench for gshare_btb_branch_predictor: directed vector table, return-stack sequence,
// randomized traffic against a reference model, and an asynchronous reset sequence.
module tb_gshare_btb_branch_predictor;
    localparam int DW        = 32;
    localparam int BTB_ROWS  = 16;
    localparam int PHT_ROWS  = 64;
    localparam int GHR_BITS  = 6;
    localparam int CTR_BITS  = 2;
    localparam int RAS_DEPTH = 4;
    localparam int IDX_BITS  = 4;
    localparam int GHR_SPAN  = 64;
    localparam int CTR_MAX   = 3;
    localparam logic [31:0] I_BEQ   = 32'h0000_0063;
    localparam logic [31:0] I_JAL   = 32'h0000_006F;
    localparam logic [31:0] I_ADD   = 32'h0000_0033;
    localparam logic [31:0] I_JALRA = 32'h0000_00EF;
    localparam logic [31:0] I_RET   = 32'h0000_8067;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        bit          stall;
        bit          uv, uc, uj, ut, um;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic [5:0]  ughr;
    } cyc_t;

    typedef struct {
        cyc_t        c;
        bit          tk;
        logic [31:0] tgt;
        logic [5:0]  ghr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    gshare_btb_branch_predictor_if #(.DATA_WIDTH(DW), .GHR_BITS(GHR_BITS)) bp_if ();

    gshare_btb_branch_predictor #(
        .DATA_WIDTH(DW), .BTB_ROWS(BTB_ROWS), .PHT_ROWS(PHT_ROWS),
        .GHR_BITS(GHR_BITS), .CTR_BITS(CTR_BITS), .RAS_DEPTH(RAS_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bp   (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: plain arrays and integer arithmetic.
    bit          m_valid [BTB_ROWS];
    logic [31:0] m_tag   [BTB_ROWS];
    logic [31:0] m_tgt   [BTB_ROWS];
    int          m_ctr   [PHT_ROWS];
    int          m_ghr;
    logic [31:0] m_ras   [RAS_DEPTH];
    int          m_sp;

    function automatic void model_reset();
        for (int i = 0; i < BTB_ROWS; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < PHT_ROWS; i++) m_ctr[i] = (1 << (CTR_BITS - 1)) - 1;
        m_ghr = 0;
        m_sp  = 0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, input logic [31:0] ins,
                                          output bit tk, output logic [31:0] tgt);
        int bi  = int'(pc >> 2) % BTB_ROWS;
        int pi  = (int'(pc >> 2) % PHT_ROWS) ^ m_ghr;
        int op  = int'(ins & 32'h7F);
        int rd  = int'((ins >> 7) & 32'h1F);
        int rs1 = int'((ins >> 15) & 32'h1F);
        bit hit = m_valid[bi] && (m_tag[bi] == (pc >> (IDX_BITS + 2)));
        tk  = 1'b0;
        tgt = pc;
        if (hit && (op == 'h6F || (op == 'h63 && m_ctr[pi] >= (1 << (CTR_BITS - 1))))) begin
            tk  = 1'b1;
            tgt = m_tgt[bi];
        end
`ifdef RAS_EN
        if (op == 'h67 && rd == 0 && (rs1 == 1 || rs1 == 5)) begin
            tk  = 1'b1;
            tgt = m_ras[(m_sp + RAS_DEPTH - 1) % RAS_DEPTH];
        end
`else
        if (rd < 0 || rs1 < 0) tk = 1'b0;
`endif
    endfunction

    function automatic void model_commit(input cyc_t c, input bit ptk);
        int op  = int'(c.instr & 32'h7F);
        int rd  = int'((c.instr >> 7) & 32'h1F);
        int rs1 = int'((c.instr >> 15) & 32'h1F);
        int ng  = m_ghr;
        int pi;
        int bi;
        if (c.uv && c.um && c.uc)      ng = (int'(c.ughr) * 2 + int'(c.ut)) % GHR_SPAN;
        else if (c.uv && c.um && c.uj) ng = int'(c.ughr);
        else if (!c.stall && op == 'h63) ng = (m_ghr * 2 + int'(ptk)) % GHR_SPAN;
        if (c.uv && c.uc) begin
            pi = (int'(c.upc >> 2) % PHT_ROWS) ^ int'(c.ughr);
            if (c.ut) m_ctr[pi] = (m_ctr[pi] < CTR_MAX) ? m_ctr[pi] + 1 : CTR_MAX;
            else      m_ctr[pi] = (m_ctr[pi] > 0) ? m_ctr[pi] - 1 : 0;
        end
        if (c.uv && c.ut && (c.uc || c.uj)) begin
            bi          = int'(c.upc >> 2) % BTB_ROWS;
            m_valid[bi] = 1'b1;
            m_tag[bi]   = c.upc >> (IDX_BITS + 2);
            m_tgt[bi]   = c.utgt;
        end
`ifdef RAS_EN
        if (!c.stall) begin
            if ((op == 'h6F || op == 'h67) && (rd == 1 || rd == 5)) begin
                m_ras[m_sp] = c.pc + 32'd4;
                m_sp        = (m_sp + 1) % RAS_DEPTH;
            end else if (op == 'h67 && rd == 0 && (rs1 == 1 || rs1 == 5)) begin
                m_sp = (m_sp + RAS_DEPTH - 1) % RAS_DEPTH;
            end
        end
`else
        if (rd < 0 || rs1 < 0) m_sp = 0;
`endif
        m_ghr = ng;
    endfunction

    // u = {valid, is_cond, is_jal, taken, mispredict}
    function automatic cyc_t mk(input logic [31:0] pc, input logic [31:0] ins, input bit st,
                                input logic [4:0] u, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic [5:0] ughr);
        cyc_t c;
        c.pc = pc;  c.instr = ins;  c.stall = st;
        c.uv = u[4]; c.uc = u[3]; c.uj = u[2]; c.ut = u[1]; c.um = u[0];
        c.upc = upc; c.utgt = utgt; c.ughr = ughr;
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input cyc_t c);
        bp_if.pc_f           = c.pc;
        bp_if.instr_f        = c.instr;
        bp_if.stall_f        = c.stall;
        bp_if.upd_valid      = c.uv;
        bp_if.upd_is_cond    = c.uc;
        bp_if.upd_is_jal     = c.uj;
        bp_if.upd_taken      = c.ut;
        bp_if.upd_mispredict = c.um;
        bp_if.upd_pc         = c.upc;
        bp_if.upd_target     = c.utgt;
        bp_if.upd_ghr        = c.ughr;
    endtask

    // Entered and left 1 time unit after a rising edge; outputs checked mid-cycle.
    task automatic drive_cycle(input cyc_t c, input bit use_model, input bit etk,
                               input logic [31:0] etgt, input logic [5:0] eghr,
                               input string name);
        bit          mtk;
        logic [31:0] mtgt;
        apply(c);
        #2;
        model_predict(c.pc, c.instr, mtk, mtgt);
        if (use_model) begin
            etk  = mtk;
            etgt = mtgt;
            eghr = 6'(m_ghr);
        end
        check({name, "_taken"}, 32'(bp_if.predict_taken_f), 32'(etk));
        check({name, "_target"}, bp_if.branch_target_f, etgt);
        check({name, "_ghr"}, 32'(bp_if.ghr_f), 32'(eghr));
        @(posedge clk);
        model_commit(c, mtk);
        #1;
    endtask

    function automatic logic [31:0] pick_instr(input int k);
        case (k)
            0:       return I_BEQ;
            1:       return I_JAL;
            2:       return I_ADD;
            3:       return I_JALRA;
            default: return I_RET;
        endcase
    endfunction

    task automatic random_cycles(input int n);
        cyc_t c;
        int   kind;
        for (int i = 0; i < n; i++) begin
            c.pc    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
            c.instr = pick_instr(int'($urandom_range(0, 4)));
            c.stall = ($urandom_range(0, 4) == 0);
            c.uv    = ($urandom_range(0, 9) < 7);
            kind    = int'($urandom_range(0, 2));
            c.uc    = (kind == 0);
            c.uj    = (kind == 1);
            c.ut    = 1'($urandom_range(0, 1));
            c.um    = ($urandom_range(0, 9) < 3);
            c.upc   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
            c.utgt  = 32'($urandom_range(0, 16383)) << 2;
            c.ughr  = 6'($urandom_range(0, 63));
            drive_cycle(c, 1'b1, 1'b0, 32'h0, 6'h0, "rand");
        end
    endtask

    vec_t vecs [19];

    initial begin
        checks   = 0;
        failures = 0;
        // Directed vectors from reset; expected values derived by hand.
        vecs[0]  = '{mk(32'h100, I_BEQ, 0, 5'b00000, 32'h0,   32'h0,   6'h00), 1'b0, 32'h100, 6'h00};
        vecs[1]  = '{mk(32'h000, I_ADD, 0, 5'b11011, 32'h100, 32'h80,  6'h00), 1'b0, 32'h000, 6'h00};
        vecs[2]  = '{mk(32'h100, I_BEQ, 0, 5'b10101, 32'h500, 32'h0,   6'h00), 1'b0, 32'h100, 6'h01};
        vecs[3]  = '{mk(32'h100, I_BEQ, 1, 5'b00000, 32'h0,   32'h0,   6'h00), 1'b1, 32'h080, 6'h00};
        vecs[4]  = '{mk(32'h100, I_BEQ, 0, 5'b11010, 32'h100, 32'h80,  6'h00), 1'b1, 32'h080, 6'h00};
        vecs[5]  = '{mk(32'h008, I_ADD, 0, 5'b11010, 32'h100, 32'h80,  6'h00), 1'b0, 32'h008, 6'h01};
        vecs[6]  = '{mk(32'h00C, I_ADD, 0, 5'b11001, 32'h100, 32'h80,  6'h00), 1'b0, 32'h00C, 6'h01};
        vecs[7]  = '{mk(32'h010, I_ADD, 0, 5'b11000, 32'h100, 32'h80,  6'h00), 1'b0, 32'h010, 6'h00};
        vecs[8]  = '{mk(32'h100, I_BEQ, 1, 5'b00000, 32'h0,   32'h0,   6'h00), 1'b0, 32'h100, 6'h00};
        vecs[9]  = '{mk(32'h010, I_ADD, 0, 5'b11010, 32'h114, 32'h300, 6'h05), 1'b0, 32'h010, 6'h00};
        vecs[10] = '{mk(32'h014, I_ADD, 0, 5'b10101, 32'h600, 32'h0,   6'h05), 1'b0, 32'h014, 6'h00};
        vecs[11] = '{mk(32'h114, I_BEQ, 0, 5'b11001, 32'h700, 32'h0,   6'h30), 1'b1, 32'h300, 6'h05};
        vecs[12] = '{mk(32'h000, I_ADD, 0, 5'b00000, 32'h0,   32'h0,   6'h00), 1'b0, 32'h000, 6'h20};
        vecs[13] = '{mk(32'h004, I_ADD, 0, 5'b10110, 32'h200, 32'h400, 6'h00), 1'b0, 32'h004, 6'h20};
        vecs[14] = '{mk(32'h200, I_JAL, 0, 5'b10110, 32'h240, 32'h500, 6'h00), 1'b1, 32'h400, 6'h20};
        vecs[15] = '{mk(32'h200, I_JAL, 0, 5'b00000, 32'h0,   32'h0,   6'h00), 1'b0, 32'h200, 6'h20};
        vecs[16] = '{mk(32'h240, I_JAL, 0, 5'b00000, 32'h0,   32'h0,   6'h00), 1'b1, 32'h500, 6'h20};
        vecs[17] = '{mk(32'h008, I_ADD, 0, 5'b01111, 32'h200, 32'h998, 6'h3F), 1'b0, 32'h008, 6'h20};
        vecs[18] = '{mk(32'h200, I_JAL, 0, 5'b00000, 32'h0,   32'h0,   6'h00), 1'b0, 32'h200, 6'h20};

        rst_n = 1'b0;
        apply(mk(32'h100, I_BEQ, 0, 5'b00000, 32'h0, 32'h0, 6'h00));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_taken", 32'(bp_if.predict_taken_f), 32'h0);
        check("reset_target", bp_if.branch_target_f, 32'h100);
        check("reset_ghr", 32'(bp_if.ghr_f), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++)
            drive_cycle(vecs[i].c, 1'b0, vecs[i].tk, vecs[i].tgt, vecs[i].ghr, $sformatf("vec%0d", i));

`ifdef RAS_EN
        drive_cycle(mk(32'h300, I_JALRA, 0, 5'b0, 0, 0, 0), 1'b0, 1'b0, 32'h300, 6'h20, "ras_call");
        drive_cycle(mk(32'h400, I_RET, 0, 5'b0, 0, 0, 0), 1'b0, 1'b1, 32'h304, 6'h20, "ras_ret");
        for (int i = 0; i < 5; i++)
            drive_cycle(mk(32'h1000 + 32'(i * 4), I_JALRA, 0, 5'b0, 0, 0, 0), 1'b0, 1'b0,
                        32'h1000 + 32'(i * 4), 6'h20, $sformatf("ras_push%0d", i));
        drive_cycle(mk(32'h400, I_RET, 0, 5'b0, 0, 0, 0), 1'b0, 1'b1, 32'h1014, 6'h20, "ras_pop0");
        drive_cycle(mk(32'h400, I_RET, 0, 5'b0, 0, 0, 0), 1'b0, 1'b1, 32'h1010, 6'h20, "ras_pop1");
        drive_cycle(mk(32'h400, I_RET, 0, 5'b0, 0, 0, 0), 1'b0, 1'b1, 32'h100C, 6'h20, "ras_pop2");
        drive_cycle(mk(32'h400, I_RET, 0, 5'b0, 0, 0, 0), 1'b0, 1'b1, 32'h1008, 6'h20, "ras_pop3");
        drive_cycle(mk(32'h400, I_RET, 0, 5'b0, 0, 0, 0), 1'b0, 1'b1, 32'h1014, 6'h20, "ras_under");
`else
        drive_cycle(mk(32'h300, I_JALRA, 0, 5'b0, 0, 0, 0), 1'b0, 1'b0, 32'h300, 6'h20, "jal_link");
        drive_cycle(mk(32'h400, I_RET, 0, 5'b0, 0, 0, 0), 1'b0, 1'b0, 32'h400, 6'h20, "jalr_nt");
`endif

        random_cycles(300);

        // Asynchronous reset with an update in flight.
        drive_cycle(mk(32'h0, I_ADD, 0, 5'b10111, 32'h200, 32'h444, 6'h2A), 1'b1, 1'b0, 0, 0, "pre_rst");
        apply(mk(32'h200, I_JAL, 0, 5'b10110, 32'h240, 32'h555, 6'h00));
        #2;
        check("pre_rst_taken", 32'(bp_if.predict_taken_f), 32'h1);
        check("pre_rst_target", bp_if.branch_target_f, 32'h444);
        check("pre_rst_ghr", 32'(bp_if.ghr_f), 32'h2A);
        rst_n = 1'b0;
        #1;
        check("async_rst_taken", 32'(bp_if.predict_taken_f), 32'h0);
        check("async_rst_target", bp_if.branch_target_f, 32'h200);
        check("async_rst_ghr", 32'(bp_if.ghr_f), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive_cycle(mk(32'h240, I_JAL, 0, 5'b0, 0, 0, 0), 1'b0, 1'b0, 32'h240, 6'h00, "post_rst_240");
        drive_cycle(mk(32'h200, I_JAL, 0, 5'b0, 0, 0, 0), 1'b0, 1'b0, 32'h200, 6'h00, "post_rst_200");

        random_cycles(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
